// File: rtl/aone_pia_uart_if.sv
// rtl/aone_pia_uart_if.sv - memory-bus bundle between the memory interface and the keyboard/display port
interface aone_pia_uart_if;
  logic       cs;
  logic [1:0] addr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output cs, addr, rd_en, wr_en, wdata, input rdata);
  modport slave  (input cs, addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/aone_pia_uart.sv
// rtl/aone_pia_uart.sv - 6820-style KBD/KBDCR/DSP/DSPCR register set at $D010-$D013 over 8N1 UART RX/TX
module aone_pia_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit AUTO_LF      = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  aone_pia_uart_if.slave bus,
  input  logic           uart_rx,
  output logic           uart_tx,
  output logic           kbd_overrun
);
  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic       rd_hit, wr_hit, kbd_read, dsp_write;
  logic [5:0] kbdcr, dspcr;
  logic [7:0] rdata;
  logic       kbd_ready;
  logic [6:0] kbd_char;
  logic [6:0] last_dsp;
  logic       tx_busy;

  assign rd_hit    = bus.cs & bus.rd_en;
  assign wr_hit    = bus.cs & bus.wr_en;
  assign kbd_read  = rd_hit && (bus.addr == 2'd0);
  assign dsp_write = wr_hit && (bus.addr == 2'd2);
  assign bus.rdata = rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 8'h00;
      kbdcr <= 6'h00;
      dspcr <= 6'h00;
    end else begin
      if (wr_hit && bus.addr == 2'd1) kbdcr <= bus.wdata[5:0];
      if (wr_hit && bus.addr == 2'd3) dspcr <= bus.wdata[5:0];
      if (rd_hit) begin
        case (bus.addr)
          2'd0:    rdata <= {1'b1, kbd_char};
          2'd1:    rdata <= {kbd_ready, kbd_overrun, kbdcr};
          2'd2:    rdata <= {tx_busy, last_dsp};
          default: rdata <= {2'b00, dspcr};
        endcase
      end
    end
  end

  rx_state_t     rx_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [6:0]    rx_shift;
  logic [6:0]    rx_char;
  logic          rx_commit;

  always_comb begin
    rx_char = rx_shift;
    if (rx_char == 7'h0A)
      rx_char = 7'h0D;
    else if (rx_char >= 7'h61 && rx_char <= 7'h7A)
      rx_char = rx_char - 7'h20;
  end

  assign rx_commit = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= 3'd0;
      rx_shift    <= 7'h00;
      kbd_char    <= 7'h00;
      kbd_ready   <= 1'b0;
      kbd_overrun <= 1'b0;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;

      if (rx_commit) begin
        kbd_char  <= rx_char;
        kbd_ready <= 1'b1;
      end else if (kbd_read) begin
        kbd_ready <= 1'b0;
      end
      if (kbd_read)
        kbd_overrun <= 1'b0;
      else if (rx_commit && kbd_ready)
        kbd_overrun <= 1'b1;

      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            rx_bit <= rx_bit + 3'd1;
            // bit 7 is never kept, so only the first seven samples shift in
            if (rx_bit != 3'd7)
              rx_shift <= {rx_sync, rx_shift[6:1]};
            else
              rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST)
            rx_state <= RX_IDLE;
          else
            rx_cnt <= rx_cnt + 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_lf_sent;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      uart_tx    <= 1'b1;
      tx_busy    <= 1'b0;
      last_dsp   <= 7'h00;
      tx_cnt     <= '0;
      tx_bit     <= 3'd0;
      tx_shift   <= 8'h00;
      tx_lf_sent <= 1'b0;
    end else begin
      if (dsp_write && !tx_busy) begin
        last_dsp <= bus.wdata[6:0];
        tx_busy  <= 1'b1;
      end

      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (tx_busy) begin
            tx_state   <= TX_START;
            uart_tx    <= 1'b0;
            tx_cnt     <= '0;
            tx_shift   <= {1'b0, last_dsp};
            tx_lf_sent <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            // the LF frame follows the CR stop bit with no idle gap
            if (AUTO_LF && !tx_lf_sent && last_dsp == 7'h0D) begin
              tx_state   <= TX_START;
              uart_tx    <= 1'b0;
              tx_shift   <= 8'h0A;
              tx_lf_sent <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
              tx_busy  <= 1'b0;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aone_pia_uart.sv
// tb/tb_aone_pia_uart.sv - directed bench for aone_pia_uart with a cycle-level line/register model
module tb_aone_pia_uart;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;
  logic kbd_overrun;

  aone_pia_uart_if bus();

  aone_pia_uart #(.CLKS_PER_BIT(CPB), .AUTO_LF(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .kbd_overrun(kbd_overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // expected uart_tx level for each upcoming cycle; empty means idle and not busy
  bit         wave_q[$];
  logic [6:0] m_char;
  bit         m_ready, m_ovr, rx_active;
  logic [5:0] m_kbdcr, m_dspcr;
  logic [6:0] m_dsp;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] kbd_map(input logic [7:0] b);
    logic [6:0] c;
    c = b[6:0];
    if (c == 7'h0A) return 7'h0D;
    if (c >= 7'h61 && c <= 7'h7A) return c - 7'h20;
    return c;
  endfunction

  task automatic model_reset();
    wave_q.delete();
    m_char = 7'h00; m_ready = 1'b0; m_ovr = 1'b0;
    m_kbdcr = 6'h00; m_dspcr = 6'h00; m_dsp = 7'h00;
    rx_active = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      repeat (CPB) wave_q.push_back(f[i]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit sel);
    bus.cs = sel; bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr_en = 1'b0;
    if (sel) begin
      case (a)
        2'd1: m_kbdcr = d[5:0];
        2'd3: m_dspcr = d[5:0];
        2'd2: if (wave_q.size() == 0) begin
          m_dsp = d[6:0];
          wave_q.push_back(1'b1);
          push_frame({1'b0, d[6:0]});
          if (d[6:0] == 7'h0D) push_frame(8'h0A);
        end
        default: ;
      endcase
    end
  endtask

  task automatic rd(input logic [1:0] a, input int lit, input string nm);
    logic [7:0] e;
    bus.cs = 1'b1; bus.rd_en = 1'b1; bus.addr = a;
    case (a)
      2'd0:    e = {1'b1, m_char};
      2'd1:    e = {m_ready, m_ovr, m_kbdcr};
      2'd2:    e = {wave_q.size() > 0, m_dsp};
      default: e = {2'b00, m_dspcr};
    endcase
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd_en = 1'b0;
    check({nm, " model"}, bus.rdata, e);
    if (lit >= 0) check({nm, " literal"}, bus.rdata, lit[7:0]);
    if (a == 2'd0) begin m_ready = 1'b0; m_ovr = 1'b0; end
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    rx_active = 1'b1;
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
    if (stop) begin
      if (m_ready) m_ovr = 1'b1;
      m_char  = kbd_map(b);
      m_ready = 1'b1;
    end
    tick(2);
    rx_active = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 * CPB && wave_q.size() > 0; i++) tick(1);
    check("tx drain", wave_q.size() == 0, 8'h01);
    tick(4);
  endtask

  always @(negedge clk) begin
    bit e;
    if (!reset) begin
      e = 1'b1;
      if (wave_q.size() > 0) e = wave_q.pop_front();
      check("uart_tx", uart_tx, e);
      if (!rx_active) check("kbd_overrun", kbd_overrun, m_ovr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.addr = 2'd0; bus.wdata = 8'h00;
    model_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset rdata", bus.rdata, 8'h00);
    check("reset uart_tx", uart_tx, 8'h01);
    tick(2);
    rd(2'd1, 8'h00, "KBDCR after reset");
    rd(2'd2, 8'h00, "DSP after reset");

    send(8'h61, 1'b1);
    rd(2'd1, 8'h80, "KBDCR after a");
    rd(2'd0, 8'hC1, "KBD a");
    rd(2'd1, 8'h00, "KBDCR after KBD read");

    send(8'h41, 1'b1);
    send(8'h42, 1'b1);
    rd(2'd1, 8'hC0, "KBDCR overrun");
    check("kbd_overrun pin", kbd_overrun, 8'h01);
    rd(2'd0, 8'hC2, "KBD after overrun");
    rd(2'd1, 8'h00, "KBDCR after overrun read");

    send(8'h7A, 1'b1); rd(2'd0, 8'hDA, "KBD z");
    send(8'h0A, 1'b1); rd(2'd0, 8'h8D, "KBD LF");
    send(8'hE1, 1'b1); rd(2'd0, 8'hC1, "KBD bit7 a");

    rx_active = 1'b1; uart_rx = 1'b0; tick(3); uart_rx = 1'b1; tick(2 * CPB); rx_active = 1'b0;
    rd(2'd1, 8'h00, "KBDCR after glitch");
    send(8'h55, 1'b0); tick(CPB);
    rd(2'd1, 8'h00, "KBDCR after framing error");
    rd(2'd0, 8'hC1, "KBD after framing error");

    wr(2'd1, 8'hFF, 1'b1); rd(2'd1, 8'h3F, "KBDCR write");
    wr(2'd3, 8'hAA, 1'b1); rd(2'd3, 8'h2A, "DSPCR write");
    wr(2'd1, 8'h00, 1'b0); rd(2'd1, 8'h3F, "KBDCR cs low");
    wr(2'd0, 8'h12, 1'b1); rd(2'd0, 8'hC1, "KBD write ignored");
    wr(2'd2, 8'h33, 1'b0); tick(4); rd(2'd2, 8'h00, "DSP cs low");

    wr(2'd2, 8'hC1, 1'b1);
    rd(2'd2, 8'hC1, "DSP busy");
    wait_idle();
    rd(2'd2, 8'h41, "DSP idle");

    wr(2'd2, 8'h0D, 1'b1);
    tick(13 * CPB);
    wr(2'd2, 8'h45, 1'b1);
    rd(2'd2, 8'h8D, "DSP busy during LF");
    wait_idle();
    rd(2'd2, 8'h0D, "DSP after CR LF");

    wr(2'd2, 8'h55, 1'b1);
    rx_active = 1'b1;
    uart_rx = 1'b0; tick(CPB);
    uart_rx = 1'b1; tick(CPB);
    uart_rx = 1'b0; tick(CPB / 2);
    reset = 1'b1;
    model_reset();
    uart_rx = 1'b1;
    @(negedge clk);
    check("uart_tx in reset", uart_tx, 8'h01);
    check("kbd_overrun in reset", kbd_overrun, 8'h00);
    tick(3);
    reset = 1'b0;
    tick(12 * CPB);
    rd(2'd1, 8'h00, "KBDCR after abort");
    rd(2'd2, 8'h00, "DSP after abort");
    rd(2'd0, 8'h80, "KBD after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
